seq_verdict_collector: RTL and testbench

SEQ_VERDICT_COLLECTOR -- requirements
Module: seq_verdict_collector

---
 rtl/seq_verdict_collector_if.sv | 45 ++++
 rtl/seq_verdict_collector.sv | 173 +++++++++++++++++
 tb/tb_seq_verdict_collector.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_verdict_collector_if.sv
// Verdict collector bus: window/verdict handshake, consumer acknowledge,
// clear strobe and the per-verdict statistics outputs.
// Optional field ts exists only when VERDICT_TIMESTAMP_EN is defined.
interface seq_verdict_collector_if;
  logic       en;
  logic       match;
  logic       fail;
  logic       rd_ack;
  logic       clr;
  logic       verdict_valid;
  logic [1:0] verdict;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic [7:0] vac_cnt;
  logic [3:0] consec_fail;
  logic       err_sticky;
  logic       overrun;
`ifdef VERDICT_TIMESTAMP_EN
  logic [15:0] ts;
`endif

`ifdef VERDICT_TIMESTAMP_EN
  modport master (
    output en, match, fail, rd_ack, clr,
    input  verdict_valid, verdict, pass_cnt, fail_cnt, vac_cnt,
    input  consec_fail, err_sticky, overrun, ts
  );
  modport slave (
    input  en, match, fail, rd_ack, clr,
    output verdict_valid, verdict, pass_cnt, fail_cnt, vac_cnt,
    output consec_fail, err_sticky, overrun, ts
  );
`else
  modport master (
    output en, match, fail, rd_ack, clr,
    input  verdict_valid, verdict, pass_cnt, fail_cnt, vac_cnt,
    input  consec_fail, err_sticky, overrun
  );
  modport slave (
    input  en, match, fail, rd_ack, clr,
    output verdict_valid, verdict, pass_cnt, fail_cnt, vac_cnt,
    output consec_fail, err_sticky, overrun
  );
`endif
endinterface

// File: rtl/seq_verdict_collector.sv
// seq_verdict_collector: collects the match/fail outputs of an upstream
// sequence checker over a window of WIN_LEN+1 cycles, reports one verdict
// (FAIL > PASS > VACUOUS) and keeps saturating per-verdict statistics plus
// a sticky error once FAIL_LIMIT consecutive FAIL verdicts are seen.
// Optional feature macro: VERDICT_TIMESTAMP_EN adds a free-running 16-bit
// cycle counter and the ts field latched at window start.
module seq_verdict_collector #(
  parameter int WIN_LEN    = 6,
  parameter int FAIL_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_verdict_collector_if.slave bus
);

  localparam logic [1:0] VERDICT_VAC  = 2'b00;
  localparam logic [1:0] VERDICT_PASS = 2'b01;
  localparam logic [1:0] VERDICT_FAIL = 2'b10;
  localparam logic [3:0] LAST_CNT     = 4'(WIN_LEN);
  localparam logic [3:0] LIMIT        = 4'(FAIL_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t     state_r;
  logic [3:0] cnt_r;
  logic       match_seen_r;
  logic       fail_seen_r;
  logic       valid_r;
  logic [1:0] verdict_r;
  logic [7:0] pass_cnt_r;
  logic [7:0] fail_cnt_r;
  logic [7:0] vac_cnt_r;
  logic [3:0] consec_r;
  logic       err_r;

  logic       report_entry_s;
  logic [1:0] verdict_next_s;
  logic [3:0] consec_next_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Decide the verdict including the final sample, so REPORT entry sees it.
  always_comb begin
    report_entry_s = 1'b0;
    verdict_next_s = VERDICT_VAC;
    consec_next_s  = 4'd0;
    if ((state_r == ST_WINDOW) && (cnt_r == LAST_CNT)) begin
      report_entry_s = 1'b1;
    end else begin
      report_entry_s = 1'b0;
    end
    if (fail_seen_r || bus.fail) begin
      verdict_next_s = VERDICT_FAIL;
    end else if (match_seen_r || bus.match) begin
      verdict_next_s = VERDICT_PASS;
    end else begin
      verdict_next_s = VERDICT_VAC;
    end
    if (verdict_next_s == VERDICT_FAIL) begin
      consec_next_s = sat_inc4(consec_r);
    end else begin
      consec_next_s = 4'd0;
    end
  end

  // Window FSM: IDLE -> WINDOW (WIN_LEN+1 samples) -> REPORT until rd_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      match_seen_r <= 1'b0;
      fail_seen_r  <= 1'b0;
      valid_r      <= 1'b0;
      verdict_r    <= VERDICT_VAC;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.en) begin
            state_r      <= ST_WINDOW;
            cnt_r        <= 4'd0;
            match_seen_r <= 1'b0;
            fail_seen_r  <= 1'b0;
          end
        end
        ST_WINDOW: begin
          match_seen_r <= match_seen_r | bus.match;
          fail_seen_r  <= fail_seen_r | bus.fail;
          if (report_entry_s) begin
            state_r   <= ST_REPORT;
            cnt_r     <= 4'd0;
            valid_r   <= 1'b1;
            verdict_r <= verdict_next_s;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_REPORT: begin
          if (bus.rd_ack) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Statistics: one saturating increment per REPORT entry; clr wins.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      pass_cnt_r <= 8'd0;
      fail_cnt_r <= 8'd0;
      vac_cnt_r  <= 8'd0;
      consec_r   <= 4'd0;
      err_r      <= 1'b0;
    end else if (report_entry_s) begin
      case (verdict_next_s)
        VERDICT_FAIL: fail_cnt_r <= sat_inc8(fail_cnt_r);
        VERDICT_PASS: pass_cnt_r <= sat_inc8(pass_cnt_r);
        default:      vac_cnt_r  <= sat_inc8(vac_cnt_r);
      endcase
      consec_r <= consec_next_s;
      if (consec_next_s >= LIMIT) begin
        err_r <= 1'b1;
      end
    end
  end

`ifdef VERDICT_TIMESTAMP_EN
  logic [15:0] cyc_r;
  logic [15:0] ts_r;

  // Free-running cycle counter; ts captures it when a window starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r <= 16'd0;
      ts_r  <= 16'd0;
    end else begin
      cyc_r <= cyc_r + 16'd1;
      if ((state_r == ST_IDLE) && bus.en) begin
        ts_r <= cyc_r;
      end
    end
  end

  assign bus.ts = ts_r;
`endif

  assign bus.verdict_valid = valid_r;
  assign bus.verdict       = verdict_r;
  assign bus.pass_cnt      = pass_cnt_r;
  assign bus.fail_cnt      = fail_cnt_r;
  assign bus.vac_cnt       = vac_cnt_r;
  assign bus.consec_fail   = consec_r;
  assign bus.err_sticky    = err_r;
  // overrun flags the very cycle a stray en is presented, hence no register.
  assign bus.overrun       = bus.en && (state_r != ST_IDLE);

endmodule

// File: tb/tb_seq_verdict_collector.sv
// Scoreboard bench for seq_verdict_collector: the stimulus process predicts
// each window's verdict and statistics from a behavioural model and queues
// them; a monitor pops and compares whenever verdict_valid rises.
module tb_seq_verdict_collector;
  localparam int WL = 6;
  localparam int FL = 3;

  typedef struct {
    int         vcyc;
    int         fcyc;
    logic [1:0] verdict;
    int         p;
    int         f;
    int         v;
    int         consec;
    int         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  int m_pass, m_fail, m_vac, m_consec, m_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_verdict_collector_if bus();

  seq_verdict_collector #(.WIN_LEN(WL), .FAIL_LIMIT(FL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_pass = 0; m_fail = 0; m_vac = 0; m_consec = 0; m_err = 0;
  endtask

  // Verdict rule: any fail -> FAIL, else any match -> PASS, else VACUOUS.
  task automatic model_report(input logic [14:0] mv, input logic [14:0] fv, output logic [1:0] vd);
    int n_fail, n_match;
    n_fail = 0; n_match = 0;
    for (int i = 0; i <= WL; i++) begin
      n_fail  += int'(fv[i]);
      n_match += int'(mv[i]);
    end
    if (n_fail > 0) begin
      vd = 2'd2;
      m_fail   = (m_fail < 255) ? m_fail + 1 : 255;
      m_consec = (m_consec < 15) ? m_consec + 1 : 15;
    end else begin
      vd = (n_match > 0) ? 2'd1 : 2'd0;
      if (n_match > 0) m_pass = (m_pass < 255) ? m_pass + 1 : 255;
      else             m_vac  = (m_vac < 255) ? m_vac + 1 : 255;
      m_consec = 0;
    end
    if (m_consec >= FL) m_err = 1;
  endtask

  task automatic idle_inputs();
    bus.en = 1'b0; bus.match = 1'b0; bus.fail = 1'b0; bus.rd_ack = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic push_exp(input int t, input int d, input logic [1:0] vd);
    exp_t e;
    e.vcyc = t + WL + 2; e.fcyc = e.vcyc + d + 1; e.verdict = vd;
    e.p = m_pass; e.f = m_fail; e.v = m_vac; e.consec = m_consec; e.err = m_err;
    sb_q.push_back(e);
  endtask

  // One window: en at T, WL+1 sample cycles, rd_ack d cycles into REPORT.
  task automatic run_window(input logic [14:0] mv, input logic [14:0] fv, input int d,
                            input bit noisy, input int clr_pos);
    logic [1:0] vd;
    @(posedge clk); #1;
    idle_inputs();
    bus.en = 1'b1;
    if (clr_pos >= 0 && clr_pos < WL) model_clear();
    model_report(mv, fv, vd);
    if (clr_pos == WL) model_clear();
    push_exp(cyc, d, vd);
    for (int i = 0; i <= WL; i++) begin
      @(posedge clk); #1;
      bus.en     = noisy && ($urandom_range(0, 7) == 0);
      bus.rd_ack = noisy && ($urandom_range(0, 7) == 0);
      bus.match  = mv[i];
      bus.fail   = fv[i];
      bus.clr    = (i == clr_pos);
    end
    for (int j = 0; j <= d; j++) begin
      @(posedge clk); #1;
      bus.en     = noisy && ($urandom_range(0, 3) == 0);
      bus.match  = noisy && ($urandom_range(0, 1) == 0);
      bus.fail   = noisy && ($urandom_range(0, 1) == 0);
      bus.clr    = 1'b0;
      bus.rd_ack = (j == d);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic do_clr();
    @(posedge clk); #1; bus.clr = 1'b1;
    @(posedge clk); #1; bus.clr = 1'b0;
    model_clear();
    @(negedge clk);
    chk("clr_err_sticky", bus.err_sticky, 0);
    chk("clr_counters", bus.pass_cnt + bus.fail_cnt + bus.vac_cnt + bus.consec_fail, 0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, bus.verdict_valid, 0);
    chk({tag, "_verdict"}, bus.verdict, 0);
    chk({tag, "_pass_cnt"}, bus.pass_cnt, 0);
    chk({tag, "_fail_cnt"}, bus.fail_cnt, 0);
    chk({tag, "_vac_cnt"}, bus.vac_cnt, 0);
    chk({tag, "_consec"}, bus.consec_fail, 0);
    chk({tag, "_err"}, bus.err_sticky, 0);
  endtask

  // Monitor: pop on each verdict_valid rise, check hold and release timing.
  initial begin
    exp_t cur;
    logic prev_v;
    prev_v = 1'b0;
    cur = '{vcyc: 0, fcyc: 0, verdict: 2'd0, p: 0, f: 0, v: 0, consec: 0, err: 0};
    forever begin
      @(negedge clk);
      if (bus.verdict_valid === 1'b1 && !prev_v) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_report at cycle %0d: got verdict_valid 1 expected 0", cyc);
        end else begin
          cur = sb_q.pop_front();
          chk("report_cycle", cyc, cur.vcyc);
          chk("verdict", bus.verdict, cur.verdict);
          chk("pass_cnt", bus.pass_cnt, cur.p);
          chk("fail_cnt", bus.fail_cnt, cur.f);
          chk("vac_cnt", bus.vac_cnt, cur.v);
          chk("consec_fail", bus.consec_fail, cur.consec);
          chk("err_sticky", bus.err_sticky, cur.err);
        end
      end else if (bus.verdict_valid === 1'b1) begin
        chk("verdict_hold", bus.verdict, cur.verdict);
      end else if (prev_v) begin
        chk("valid_fall_cycle", cyc, cur.fcyc);
      end
      prev_v = (bus.verdict_valid === 1'b1);
    end
  end

  initial begin
    int t;
    logic [14:0] mv, fv;
    idle_inputs();
    model_clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_cleared("reset");
    chk("reset_overrun", bus.overrun, 0);

    // Pass window: match one sample in (T+3).
    run_window(15'd4, 15'd0, 1, 1'b0, -1);
    // Match and fail together on the last sample: FAIL wins.
    run_window(15'(1 << WL), 15'(1 << WL), 0, 1'b0, -1);
    // Two more FAIL windows reach FAIL_LIMIT, then a PASS keeps err_sticky.
    run_window(15'd0, 15'd1, 2, 1'b0, -1);
    run_window(15'd0, 15'd8, 0, 1'b0, -1);
    run_window(15'd2, 15'd0, 0, 1'b0, -1);
    do_clr();

    // en held across the whole window; rd_ack with en leaves REPORT.
    @(posedge clk); #1;
    idle_inputs();
    bus.en = 1'b1;
    begin
      logic [1:0] vd;
      model_report(15'd0, 15'd0, vd);
      push_exp(cyc, 1, vd);
    end
    @(negedge clk);
    chk("overrun_idle", bus.overrun, 0);
    for (int k = 1; k <= WL + 3; k++) begin
      @(posedge clk); #1;
      bus.en = 1'b1;
      bus.rd_ack = (k == WL + 3);
      @(negedge clk);
      chk("overrun_pulse", bus.overrun, 1);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("overrun_after", bus.overrun, 0);
    repeat (WL + 4) @(posedge clk);

    // Randomized windows with stray en/rd_ack and occasional clr.
    for (int n = 0; n < 60; n++) begin
      mv = ($urandom_range(0, 1) == 0) ? 15'($urandom) : 15'd0;
      fv = ($urandom_range(0, 2) == 0) ? 15'($urandom) : 15'd0;
      run_window(mv, fv, int'($urandom_range(0, 2)), 1'b1,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WL)) : -1);
    end

    // Reset in the middle of a window: discarded, nothing reported.
    run_window(15'd1, 15'd0, 0, 1'b0, -1);
    @(posedge clk); #1;
    idle_inputs();
    bus.en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      bus.en = 1'b0;
      bus.match = 1'($urandom_range(0, 1));
      bus.fail  = 1'($urandom_range(0, 1));
      rst = (k == 4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    chk_cleared("midwin_reset");
    repeat (WL + 4) @(posedge clk);
    run_window(15'd0, 15'd2, 0, 1'b0, -1);

    // Saturation: 256 VACUOUS windows, then clr on the next increment.
    do_clr();
    for (int n = 0; n < 256; n++) run_window(15'd0, 15'd0, 0, 1'b0, -1);
    @(negedge clk);
    chk("vac_saturated", bus.vac_cnt, 255);
    run_window(15'd0, 15'd0, 0, 1'b0, WL);
    @(negedge clk);
    chk("vac_cleared", bus.vac_cnt, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    chk("final_valid", bus.verdict_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
